game_flow_controller: RTL and testbench

Parametrised top-level game-flow FSM for the ball-shooting game. It sequences the welcome, play, pause, level-complete, game-over and victory phases. It owns the lives counter, the level counter, post-hit invulnerability and a pool of NUM_ROPES independent ropes. It sits between the keyboard decoder, the collision detector and the object drawers, and replaces the single-rope, single-life flow controller.

---
 rtl/game_flow_controller.sv | 237 +++++++++++++++++++++++
 tb/tb_game_flow_controller.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/game_flow_controller.sv
// game_flow_controller: top-level game-flow FSM for the ball-shooting game; owns lives, level,
// post-hit invulnerability and a pool of ropes. Optional macro GAME_FLOW_BLINK_EN blinks the player while invulnerable.
module game_flow_controller #(
    parameter int LIVES_INIT        = 3,
    parameter int NUM_LEVELS        = 4,
    parameter int NUM_ROPES         = 2,
    parameter int COORD_W           = 11,
    parameter int INVULN_FRAMES     = 60,
    parameter int LEVEL_DONE_FRAMES = 120
) (
    input  logic                           clk,
    input  logic                           resetN,
    input  logic                           startOfFrame,
    input  logic                           rightArrow,
    input  logic                           leftArrow,
    input  logic                           spaceBar,
    input  logic                           pauseKey,
    input  logic                           col_player_ball,
    input  logic [NUM_ROPES-1:0]           col_rope_ball,
    input  logic [NUM_ROPES*COORD_W-1:0]   ropeTopY,
    input  logic [COORD_W-1:0]             playerX,
    input  logic                           allBallsCleared,
    output logic [2:0]                     gameState,
    output logic [3:0]                     level,
    output logic [3:0]                     lives,
    output logic                           playerMoveRight,
    output logic                           playerMoveLeft,
    output logic                           playerVisible,
    output logic                           ballVisible,
    output logic [NUM_ROPES-1:0]           ropeActive,
    output logic [NUM_ROPES*COORD_W-1:0]   ropeX,
    output logic                           levelStart
);

    // state      | meaning
    // WELCOME    | title screen, waiting for space
    // PLAY       | level running; ropes, hits and clears are processed
    // PAUSED     | everything frozen until pause is pressed again
    // LEVEL_DONE | level cleared; hold for LEVEL_DONE_FRAMES frames
    // GAME_OVER  | last life lost; space returns to WELCOME
    // VICTORY    | final level cleared; space returns to WELCOME
    typedef enum logic [2:0] {
        S_WELCOME    = 3'd0,
        S_PLAY       = 3'd1,
        S_PAUSED     = 3'd2,
        S_LEVEL_DONE = 3'd3,
        S_GAME_OVER  = 3'd4,
        S_VICTORY    = 3'd5
    } state_t;

    localparam logic [3:0] LIVES_LOAD = 4'(LIVES_INIT);
    localparam logic [3:0] LAST_LEVEL = 4'(NUM_LEVELS - 1);
    localparam logic [7:0] INV_LOAD   = 8'(INVULN_FRAMES);
    localparam logic [7:0] LD_LOAD    = 8'(LEVEL_DONE_FRAMES);

    state_t                         r_state;
    logic [3:0]                     r_level;
    logic [3:0]                     r_lives;
    logic [7:0]                     r_invuln;
    logic [7:0]                     r_ld_cnt;
    logic                           r_space_d1;
    logic                           r_pause_d1;
    logic                           r_level_start;
    logic [NUM_ROPES-1:0]           r_rope_active;
    logic [NUM_ROPES*COORD_W-1:0]   r_rope_x;

    state_t                         w_state_nxt;
    logic [3:0]                     w_level_nxt;
    logic [3:0]                     w_lives_nxt;
    logic [7:0]                     w_invuln_nxt;
    logic [7:0]                     w_ld_nxt;
    logic                           w_level_start_nxt;
    logic [NUM_ROPES-1:0]           w_rope_active_nxt;
    logic [NUM_ROPES*COORD_W-1:0]   w_rope_x_nxt;
    logic [NUM_ROPES-1:0]           w_kill;
    logic                           w_launched;
    logic                           w_space_press;
    logic                           w_pause_press;
    logic                           w_hit;

    assign w_space_press = spaceBar & ~r_space_d1;
    assign w_pause_press = pauseKey & ~r_pause_d1;
    assign w_hit         = col_player_ball && (r_invuln == 8'd0);

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            r_state       <= S_WELCOME;
            r_level       <= 4'd0;
            r_lives       <= LIVES_LOAD;
            r_invuln      <= 8'd0;
            r_ld_cnt      <= 8'd0;
            r_space_d1    <= 1'b0;
            r_pause_d1    <= 1'b0;
            r_level_start <= 1'b0;
            r_rope_active <= '0;
            r_rope_x      <= '0;
        end else begin
            r_state       <= w_state_nxt;
            r_level       <= w_level_nxt;
            r_lives       <= w_lives_nxt;
            r_invuln      <= w_invuln_nxt;
            r_ld_cnt      <= w_ld_nxt;
            r_space_d1    <= spaceBar;
            r_pause_d1    <= pauseKey;
            r_level_start <= w_level_start_nxt;
            r_rope_active <= w_rope_active_nxt;
            r_rope_x      <= w_rope_x_nxt;
        end
    end

    always_comb begin
        w_state_nxt       = r_state;
        w_level_nxt       = r_level;
        w_lives_nxt       = r_lives;
        w_invuln_nxt      = r_invuln;
        w_ld_nxt          = r_ld_cnt;
        w_level_start_nxt = 1'b0;
        case (r_state)
            S_WELCOME: begin
                if (w_space_press) begin
                    w_state_nxt       = S_PLAY;
                    w_level_nxt       = 4'd0;
                    w_lives_nxt       = LIVES_LOAD;
                    w_invuln_nxt      = 8'd0;
                    w_level_start_nxt = 1'b1;
                end
            end
            S_PLAY: begin
                if (w_hit) begin
                    w_lives_nxt  = (r_lives != 4'd0) ? r_lives - 4'd1 : 4'd0;
                    w_invuln_nxt = INV_LOAD;
                end else if (startOfFrame && (r_invuln != 8'd0)) begin
                    w_invuln_nxt = r_invuln - 8'd1;
                end
                // a fatal hit outranks a simultaneous clear, which outranks pause
                if (w_hit && (r_lives <= 4'd1)) begin
                    w_state_nxt = S_GAME_OVER;
                end else if (allBallsCleared) begin
                    w_state_nxt = S_LEVEL_DONE;
                    w_ld_nxt    = LD_LOAD;
                end else if (w_pause_press) begin
                    w_state_nxt = S_PAUSED;
                end
            end
            S_PAUSED: begin
                if (w_pause_press) begin
                    w_state_nxt = S_PLAY;
                end
            end
            S_LEVEL_DONE: begin
                if (r_ld_cnt == 8'd0) begin
                    if (r_level >= LAST_LEVEL) begin
                        w_state_nxt = S_VICTORY;
                    end else begin
                        w_state_nxt       = S_PLAY;
                        w_level_nxt       = r_level + 4'd1;
                        w_invuln_nxt      = 8'd0;
                        w_level_start_nxt = 1'b1;
                    end
                end else if (startOfFrame) begin
                    w_ld_nxt = r_ld_cnt - 8'd1;
                end
            end
            S_GAME_OVER, S_VICTORY: begin
                if (w_space_press) begin
                    w_state_nxt = S_WELCOME;
                end
            end
            default: begin
                w_state_nxt = S_WELCOME;
            end
        endcase
    end

    // Rope pool: a launch may only take a rope that is idle and not being killed this cycle.
    always_comb begin
        w_kill            = '0;
        w_launched        = 1'b0;
        w_rope_active_nxt = r_rope_active;
        w_rope_x_nxt      = r_rope_x;
        for (int i = 0; i < NUM_ROPES; i++) begin
            w_kill[i] = (ropeTopY[i*COORD_W +: COORD_W] == '0) || col_rope_ball[i];
        end
        if (r_state == S_PLAY) begin
            w_rope_active_nxt = r_rope_active & ~w_kill;
            for (int i = 0; i < NUM_ROPES; i++) begin
                if (w_space_press && !w_launched && !r_rope_active[i] && !w_kill[i]) begin
                    w_rope_active_nxt[i]                 = 1'b1;
                    w_rope_x_nxt[i*COORD_W +: COORD_W]   = playerX;
                    w_launched                           = 1'b1;
                end
            end
        end
        if ((w_state_nxt != S_PLAY) && (w_state_nxt != S_PAUSED)) begin
            w_rope_active_nxt = '0;
            w_rope_x_nxt      = '0;
        end
    end

    always_comb begin
        playerMoveRight = 1'b0;
        playerMoveLeft  = 1'b0;
        playerVisible   = 1'b0;
        ballVisible     = 1'b0;
        case (r_state)
            S_PLAY: begin
                playerMoveRight = rightArrow;
                playerMoveLeft  = leftArrow;
                playerVisible   = 1'b1;
                ballVisible     = 1'b1;
`ifdef GAME_FLOW_BLINK_EN
                if (r_invuln != 8'd0) begin
                    playerVisible = ~r_invuln[3];
                end
`endif
            end
            S_PAUSED: begin
                playerVisible = 1'b1;
                ballVisible   = 1'b1;
            end
            S_LEVEL_DONE: begin
                playerVisible = 1'b1;
            end
            default: begin
                playerVisible = 1'b0;
            end
        endcase
    end

    assign gameState  = r_state;
    assign level      = r_level;
    assign lives      = r_lives;
    assign ropeActive = r_rope_active;
    assign ropeX      = r_rope_x;
    assign levelStart = r_level_start;

endmodule

// File: tb/tb_game_flow_controller.sv
// Scoreboard bench for game_flow_controller: a driver applies directed and random stimulus on the
// falling edge and queues the expected response from a phase-level game model; a monitor checks it.
module tb_game_flow_controller;

    localparam int LV  = 3;
    localparam int NL  = 4;
    localparam int NR  = 2;
    localparam int CW  = 11;
    localparam int INV = 60;
    localparam int LDF = 120;

    localparam int PH_WELCOME = 0, PH_PLAY = 1, PH_PAUSED = 2, PH_DONE = 3, PH_OVER = 4, PH_WIN = 5;

    logic               clk = 1'b0;
    logic               resetN = 1'b0;
    logic               startOfFrame = 1'b0;
    logic               rightArrow = 1'b0, leftArrow = 1'b0;
    logic               spaceBar = 1'b0, pauseKey = 1'b0;
    logic               col_player_ball = 1'b0;
    logic [NR-1:0]      col_rope_ball = '0;
    logic [NR*CW-1:0]   ropeTopY = '0;
    logic [CW-1:0]      playerX = '0;
    logic               allBallsCleared = 1'b0;
    logic [2:0]         gameState;
    logic [3:0]         level, lives;
    logic               playerMoveRight, playerMoveLeft, playerVisible, ballVisible;
    logic [NR-1:0]      ropeActive;
    logic [NR*CW-1:0]   ropeX;
    logic               levelStart;

    game_flow_controller #(
        .LIVES_INIT(LV), .NUM_LEVELS(NL), .NUM_ROPES(NR), .COORD_W(CW),
        .INVULN_FRAMES(INV), .LEVEL_DONE_FRAMES(LDF)
    ) dut (
        .clk(clk), .resetN(resetN), .startOfFrame(startOfFrame),
        .rightArrow(rightArrow), .leftArrow(leftArrow),
        .spaceBar(spaceBar), .pauseKey(pauseKey),
        .col_player_ball(col_player_ball), .col_rope_ball(col_rope_ball),
        .ropeTopY(ropeTopY), .playerX(playerX), .allBallsCleared(allBallsCleared),
        .gameState(gameState), .level(level), .lives(lives),
        .playerMoveRight(playerMoveRight), .playerMoveLeft(playerMoveLeft),
        .playerVisible(playerVisible), .ballVisible(ballVisible),
        .ropeActive(ropeActive), .ropeX(ropeX), .levelStart(levelStart)
    );

    always #5 clk = ~clk;

    typedef struct {
        int     st, lvl, lv;
        longint ract, rx;
        bit     ls, mr, ml, pv, bv;
    } exp_t;

    exp_t q[$];
    int   n_vec = 0;
    int   n_err = 0;

    // pending stimulus, applied at the next falling edge
    bit p_right, p_left, p_space, p_pause, p_colp, p_clr, p_sof;
    bit p_colr[NR];
    int p_topy[NR];
    int p_px;

    // game model
    int m_phase, m_level, m_lives, m_inv, m_ld;
    bit m_sp_prev, m_pp_prev, m_ls;
    bit m_act[NR];
    int m_x[NR];

    function automatic void check(string nm, longint act, longint exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            if (n_err <= 40) $display("FAIL %s at %0t: got %0d, expected %0d", nm, $time, act, exp);
        end
    endfunction

    function automatic void model_reset();
        m_phase = PH_WELCOME; m_level = 0; m_lives = LV; m_inv = 0; m_ld = 0;
        m_sp_prev = 0; m_pp_prev = 0; m_ls = 0;
        for (int i = 0; i < NR; i++) begin m_act[i] = 0; m_x[i] = 0; end
    endfunction

    function automatic void drop_ropes();
        for (int i = 0; i < NR; i++) begin m_act[i] = 0; m_x[i] = 0; end
    endfunction

    function automatic void model_step();
        bit sp, pp, hit, done;
        bit was_act[NR];
        bit kill[NR];
        sp = p_space && !m_sp_prev;
        pp = p_pause && !m_pp_prev;
        m_sp_prev = p_space;
        m_pp_prev = p_pause;
        m_ls = 0;
        if (m_phase == PH_WELCOME) begin
            if (sp) begin
                m_phase = PH_PLAY; m_level = 0; m_lives = LV; m_inv = 0; m_ls = 1;
                drop_ropes();
            end
        end else if (m_phase == PH_PLAY) begin
            for (int i = 0; i < NR; i++) begin
                was_act[i] = m_act[i];
                kill[i] = (p_topy[i] == 0) || p_colr[i];
                if (kill[i]) m_act[i] = 0;
            end
            done = 0;
            for (int i = 0; i < NR; i++)
                if (sp && !done && !was_act[i] && !kill[i]) begin
                    m_act[i] = 1; m_x[i] = p_px; done = 1;
                end
            hit = p_colp && (m_inv == 0);
            if (hit) begin
                m_lives = (m_lives > 0) ? m_lives - 1 : 0;
                m_inv = INV;
            end else if (p_sof && m_inv > 0) m_inv--;
            if (hit && m_lives == 0) begin
                m_phase = PH_OVER; drop_ropes();
            end else if (p_clr) begin
                m_phase = PH_DONE; m_ld = LDF; drop_ropes();
            end else if (pp) m_phase = PH_PAUSED;
        end else if (m_phase == PH_PAUSED) begin
            if (pp) m_phase = PH_PLAY;
        end else if (m_phase == PH_DONE) begin
            if (m_ld == 0) begin
                if (m_level == NL - 1) m_phase = PH_WIN;
                else begin
                    m_level++; m_phase = PH_PLAY; m_inv = 0; m_ls = 1;
                end
            end else if (p_sof) m_ld--;
        end else begin
            if (sp) m_phase = PH_WELCOME;
        end
    endfunction

    function automatic exp_t expected();
        exp_t e;
        e.st = m_phase; e.lvl = m_level; e.lv = m_lives; e.ls = m_ls;
        e.ract = 0; e.rx = 0;
        for (int i = 0; i < NR; i++) begin
            e.ract = e.ract + (longint'(m_act[i]) << i);
            e.rx   = e.rx + (longint'(m_x[i]) << (i * CW));
        end
        e.mr = (m_phase == PH_PLAY) && p_right;
        e.ml = (m_phase == PH_PLAY) && p_left;
        e.pv = (m_phase == PH_PLAY) || (m_phase == PH_PAUSED);
`ifdef GAME_FLOW_BLINK_EN
        if (m_phase == PH_PLAY && m_inv > 0) e.pv = ((m_inv / 8) % 2) == 0;
`endif
        e.bv = (m_phase == PH_PLAY) || (m_phase == PH_PAUSED);
        return e;
    endfunction

    task automatic cycle();
        @(negedge clk);
        resetN = 1'b1;
        rightArrow = p_right; leftArrow = p_left;
        spaceBar = p_space; pauseKey = p_pause;
        col_player_ball = p_colp; allBallsCleared = p_clr; startOfFrame = p_sof;
        playerX = CW'(p_px);
        for (int i = 0; i < NR; i++) begin
            col_rope_ball[i] = p_colr[i];
            ropeTopY[i*CW +: CW] = CW'(p_topy[i]);
        end
        model_step();
        q.push_back(expected());
    endtask

    task automatic run(input int n);
        for (int k = 0; k < n; k++) cycle();
    endtask

    task automatic press_space();
        p_space = 1; cycle(); p_space = 0; cycle();
    endtask

    task automatic press_pause();
        p_pause = 1; cycle(); p_pause = 0; cycle();
    endtask

    task automatic idle_inputs();
        p_right = 0; p_left = 0; p_space = 0; p_pause = 0; p_colp = 0; p_clr = 0; p_sof = 0;
        p_px = 0;
        for (int i = 0; i < NR; i++) begin p_colr[i] = 0; p_topy[i] = 500; end
    endtask

    task automatic do_reset();
        @(negedge clk);
        resetN = 1'b0;
        spaceBar = 0; pauseKey = 0;
        model_reset();
        #1;
        check("rst_state", gameState, 0);
        check("rst_level", level, 0);
        check("rst_lives", lives, LV);
        check("rst_ropeActive", ropeActive, 0);
        check("rst_ropeX", ropeX, 0);
        check("rst_levelStart", levelStart, 0);
        p_space = 0; p_pause = 0;
    endtask

    // monitor: every registered update is compared against the queued expectation
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                check("gameState", gameState, e.st);
                check("level", level, e.lvl);
                check("lives", lives, e.lv);
                check("ropeActive", ropeActive, e.ract);
                check("ropeX", ropeX, e.rx);
                check("levelStart", levelStart, e.ls);
                if (e.st != PH_DONE && e.st != PH_WELCOME) begin
                    check("moveRight", playerMoveRight, e.mr);
                    check("moveLeft", playerMoveLeft, e.ml);
                    check("playerVisible", playerVisible, e.pv);
                end
                if (e.st != PH_WELCOME) check("ballVisible", ballVisible, e.bv);
            end
        end
    end

    initial begin
        idle_inputs();
        model_reset();
        do_reset();
        run(2);
        // game start
        press_space();
        run(2);
        // rope pool
        p_px = 100; press_space();
        p_px = 200; press_space();
        p_px = 300; press_space();
        p_topy[0] = 0; cycle(); p_topy[0] = 500; run(2);
        // both arrows in play
        p_right = 1; p_left = 1; run(3); p_right = 0; p_left = 0;
        // held collision over 100 frames
        p_colp = 1;
        for (int f = 0; f < 100; f++) begin p_sof = 1; cycle(); p_sof = 0; cycle(); end
        p_colp = 0; p_sof = 1; run(150); p_sof = 0;
        p_colp = 1; cycle(); p_colp = 0; run(2);
        press_space();
        // four levels to victory
        press_space();
        for (int l = 0; l < NL; l++) begin
            p_clr = 1; cycle(); p_clr = 0;
            p_sof = 1; run(125); p_sof = 0;
        end
        press_space();
        press_space();
        // pause with rope active and collision asserted
        p_px = 321; press_space();
        press_pause();
        p_colp = 1; run(4); press_space(); p_right = 1; run(3); p_right = 0; p_colp = 0;
        press_pause();
        run(3);
        // random play, with occasional mid-game reset
        for (int k = 0; k < 15000; k++) begin
            if ($urandom_range(2999) == 0) do_reset();
            p_right = 1'($urandom_range(1));
            p_left  = 1'($urandom_range(1));
            if ($urandom_range(5) == 0) p_space = ~p_space;
            if ($urandom_range(39) == 0) p_pause = ~p_pause;
            p_colp = ($urandom_range(19) == 0);
            p_clr  = ($urandom_range(299) == 0);
            p_sof  = ($urandom_range(3) == 0);
            p_px   = int'($urandom_range(2047));
            for (int i = 0; i < NR; i++) begin
                p_colr[i] = ($urandom_range(15) == 0);
                p_topy[i] = ($urandom_range(9) == 0) ? 0 : int'($urandom_range(2047, 1));
            end
            cycle();
        end
        @(posedge clk);
        #2;
        check("queue_drained", q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
